// File: rtl/ins_fetch_queue_if.sv
// ins_fetch_queue_if: fetch-stage bundle between I-cache/BIU, interrupt controller and ID.
interface ins_fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic [3:0]    priv;
    logic          int_req;
    logic          pip_flush;
    logic [63:0]   new_pc;
    logic [63:0]   addr;
    logic          rd;
    logic [3:0]    if_priv;
    logic [63:0]   ins_in;
    logic          ins_acc_fault_biu;
    logic          ins_page_fault_biu;
    logic          cache_ready;
    logic          id_ready;
    logic [31:0]   ins_out;
    logic [63:0]   ins_pc;
    logic          ins_acc_fault;
    logic          ins_addr_mis;
    logic          ins_page_fault;
    logic          int_acc;
    logic          valid;
    logic [CW-1:0] q_count;

    modport master (
        input  priv, int_req, pip_flush, new_pc, ins_in, ins_acc_fault_biu,
               ins_page_fault_biu, cache_ready, id_ready,
        output addr, rd, if_priv, ins_out, ins_pc, ins_acc_fault, ins_addr_mis,
               ins_page_fault, int_acc, valid, q_count
    );
    modport slave (
        output priv, int_req, pip_flush, new_pc, ins_in, ins_acc_fault_biu,
               ins_page_fault_biu, cache_ready, id_ready,
        input  addr, rd, if_priv, ins_out, ins_pc, ins_acc_fault, ins_addr_mis,
               ins_page_fault, int_acc, valid, q_count
    );
endinterface

// File: rtl/ins_fetch_queue.sv
// ins_fetch_queue: IF stage with a DEPTH-entry prefetch queue splitting 64-bit beats
// into 32-bit instructions, tagging PC/fault flags and halting after a fault until flush.
module ins_fetch_queue #(
    parameter logic [63:0] PC_RST = 64'h0000_0000_0000_0000,
    parameter int          DEPTH  = 4,
    parameter int          CW     = $clog2(DEPTH) + 1
) (
    input logic               clk,
    input logic               rst,
    ins_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t        r_state, w_state_nxt;
    logic [63:0]   r_pc, w_pc_nxt;
    logic [PW-1:0] r_wp, r_rp, w_wp1;
    logic [CW-1:0] r_cnt, w_free;
    logic [31:0]   r_ins [DEPTH];
    logic [63:0]   r_epc [DEPTH];
    logic [2:0]    r_flg [DEPTH];
    logic          w_run_ok, w_rd, w_acc, w_fault, w_mis, w_pop, w_valid;
    logic [1:0]    w_npush;
    logic [31:0]   w_ins0;
    logic [2:0]    w_flg0;

    assign w_free   = CW'(DEPTH) - r_cnt;
    assign w_run_ok = (r_state == RUN) & !bus.pip_flush;
    assign w_rd     = !rst & w_run_ok & (w_free >= CW'(2)) & (r_pc[1:0] == 2'b00);
    assign w_acc    = w_rd & bus.cache_ready;
    assign w_fault  = bus.ins_acc_fault_biu | bus.ins_page_fault_biu;
    assign w_mis    = w_run_ok & (r_pc[1:0] != 2'b00) & (w_free != '0);
    assign w_valid  = r_cnt != '0;
    assign w_pop    = w_valid & bus.id_ready & !bus.pip_flush;
    assign w_wp1    = r_wp + PW'(1);
    // A clean beat at a doubleword-aligned pc yields two instructions, otherwise one
    assign w_npush  = w_acc ? ((w_fault | r_pc[2]) ? 2'd1 : 2'd2) : {1'b0, w_mis};
    assign w_ins0   = (!w_acc | w_fault) ? 32'h0 : (r_pc[2] ? bus.ins_in[63:32] : bus.ins_in[31:0]);
    assign w_flg0   = w_acc ? {bus.ins_acc_fault_biu, bus.ins_page_fault_biu, 1'b0} : 3'b001;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (bus.pip_flush) begin
            w_state_nxt = RUN;
            w_pc_nxt    = bus.new_pc;
        end else begin
            w_state_nxt = ((w_acc & w_fault) | w_mis) ? HALT : r_state;
            w_pc_nxt    = (w_acc & !w_fault) ? r_pc + (r_pc[2] ? 64'd4 : 64'd8) : r_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= PC_RST;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_wp    <= bus.pip_flush ? '0 : r_wp + PW'(w_npush);
            r_rp    <= bus.pip_flush ? '0 : r_rp + PW'(w_pop);
            r_cnt   <= bus.pip_flush ? '0 : r_cnt + CW'(w_npush) - CW'(w_pop);
        end
    end

    // Payload needs no reset: head outputs are masked by valid
    always_ff @(posedge clk) begin
        if (w_npush != 2'd0) begin
            r_ins[r_wp] <= w_ins0;
            r_epc[r_wp] <= r_pc;
            r_flg[r_wp] <= w_flg0;
        end
        if (w_npush == 2'd2) begin
            r_ins[w_wp1] <= bus.ins_in[63:32];
            r_epc[w_wp1] <= r_pc + 64'd4;
            r_flg[w_wp1] <= 3'b000;
        end
    end

    assign bus.addr           = r_pc;
    assign bus.rd             = w_rd;
    assign bus.if_priv        = bus.priv;
    assign bus.valid          = w_valid;
    assign bus.q_count        = r_cnt;
    assign bus.ins_out        = w_valid ? r_ins[r_rp] : 32'h0;
    assign bus.ins_pc         = w_valid ? r_epc[r_rp] : 64'h0;
    assign bus.ins_acc_fault  = w_valid & r_flg[r_rp][2];
    assign bus.ins_page_fault = w_valid & r_flg[r_rp][1];
    assign bus.ins_addr_mis   = w_valid & r_flg[r_rp][0];
    assign bus.int_acc        = w_valid & bus.int_req;
endmodule

// File: tb/tb_ins_fetch_queue.sv
// tb_ins_fetch_queue: directed vector table plus random traffic checked against a queue-based model.
module tb_ins_fetch_queue;
    localparam logic [63:0] PC_RST = 64'h8000_0000;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] B1     = 64'hBBBB_BBBB_AAAA_AAAA;
    localparam logic [63:0] B2     = 64'h2222_2222_1111_1111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ins_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    ins_fetch_queue #(.PC_RST(PC_RST), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {logic [31:0] ins; logic [63:0] pc; logic [2:0] flg;} ent_t;
    typedef struct {
        logic fl; logic [63:0] npc; logic cr; logic [63:0] beat; logic acc, page, idr, irq;
        logic e_rd; logic [63:0] e_addr; logic e_valid; logic [2:0] e_cnt;
        logic [31:0] e_ins; logic [63:0] e_ipc; logic [2:0] e_flg; logic e_iacc;
    } vec_t;

    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_halt;
    int          errs = 0, checks = 0;
    int          tbl_idx = -1;
    vec_t        tv[18];
    bit          stream = 0, have_prev = 0;
    logic [63:0] prev_pc;
    int          npops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic [63:0] npc, input logic cr, input logic [63:0] beat,
                                input logic acc, input logic page, input logic idr, input logic irq,
                                input logic e_rd, input logic [63:0] e_addr, input logic e_valid,
                                input logic [2:0] e_cnt, input logic [31:0] e_ins, input logic [63:0] e_ipc,
                                input logic [2:0] e_flg, input logic e_iacc);
        vec_t v;
        v.fl = fl; v.npc = npc; v.cr = cr; v.beat = beat; v.acc = acc; v.page = page; v.idr = idr; v.irq = irq;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_cnt = e_cnt;
        v.e_ins = e_ins; v.e_ipc = e_ipc; v.e_flg = e_flg; v.e_iacc = e_iacc;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic [63:0] npc, input logic cr, input logic [63:0] beat,
                         input logic acc, input logic page, input logic idr, input logic irq);
        bus.pip_flush = fl; bus.new_pc = npc; bus.cache_ready = cr; bus.ins_in = beat;
        bus.ins_acc_fault_biu = acc; bus.ins_page_fault_biu = page; bus.id_ready = idr; bus.int_req = irq;
        bus.priv = 4'($urandom);
    endtask

    function automatic bit m_rd();
        return !m_halt && !bus.pip_flush && (DEPTH - q.size() >= 2) && (m_pc[1:0] == 2'b00);
    endfunction

    task automatic model_reset();
        q.delete(); m_pc = PC_RST; m_halt = 0;
    endtask

    task automatic model_cmp();
        bit   v;
        ent_t h;
        v = q.size() != 0;
        h = v ? q[0] : '0;
        chk("addr", bus.addr, m_pc);
        chk("rd", bus.rd, m_rd());
        chk("valid", bus.valid, v);
        chk("q_count", bus.q_count, q.size());
        chk("ins_out", bus.ins_out, h.ins);
        chk("ins_pc", bus.ins_pc, h.pc);
        chk("flags", {bus.ins_acc_fault, bus.ins_page_fault, bus.ins_addr_mis}, h.flg);
        chk("int_acc", bus.int_acc, v & bus.int_req);
        chk("if_priv", bus.if_priv, bus.priv);
    endtask

    task automatic model_upd();
        int free;
        bit r;
        free = DEPTH - q.size();
        r = m_rd();
        if (bus.pip_flush) begin
            q.delete(); m_pc = bus.new_pc; m_halt = 0;
        end else begin
            if (q.size() != 0 && bus.id_ready) void'(q.pop_front());
            if (r && bus.cache_ready) begin
                if (bus.ins_acc_fault_biu || bus.ins_page_fault_biu) begin
                    q.push_back({32'h0, m_pc, bus.ins_acc_fault_biu, bus.ins_page_fault_biu, 1'b0});
                    m_halt = 1;
                end else if (!m_pc[2]) begin
                    q.push_back({bus.ins_in[31:0], m_pc, 3'b000});
                    q.push_back({bus.ins_in[63:32], m_pc + 64'd4, 3'b000});
                    m_pc += 64'd8;
                end else begin
                    q.push_back({bus.ins_in[63:32], m_pc, 3'b000});
                    m_pc += 64'd4;
                end
            end else if (!m_halt && m_pc[1:0] != 2'b00 && free >= 1) begin
                q.push_back({32'h0, m_pc, 3'b001});
                m_halt = 1;
            end
        end
    endtask

    task automatic step();
        #1;
        if (tbl_idx >= 0) begin
            vec_t t;
            t = tv[tbl_idx];
            chk($sformatf("vec%0d_rd", tbl_idx), bus.rd, t.e_rd);
            chk($sformatf("vec%0d_addr", tbl_idx), bus.addr, t.e_addr);
            chk($sformatf("vec%0d_valid", tbl_idx), bus.valid, t.e_valid);
            chk($sformatf("vec%0d_cnt", tbl_idx), bus.q_count, t.e_cnt);
            chk($sformatf("vec%0d_ins", tbl_idx), bus.ins_out, t.e_ins);
            chk($sformatf("vec%0d_ipc", tbl_idx), bus.ins_pc, t.e_ipc);
            chk($sformatf("vec%0d_flg", tbl_idx), {bus.ins_acc_fault, bus.ins_page_fault, bus.ins_addr_mis}, t.e_flg);
            chk($sformatf("vec%0d_iacc", tbl_idx), bus.int_acc, t.e_iacc);
        end
        if (stream) begin
            chk("stream_qcnt_le4", bus.q_count <= 3'(DEPTH), 1'b1);
            if (bus.valid & bus.id_ready) begin
                if (have_prev) chk("stream_seq", bus.ins_pc, prev_pc + 64'd4);
                prev_pc = bus.ins_pc; have_prev = 1; npops++;
            end
        end
        model_cmp();
        model_upd();
        @(negedge clk);
    endtask

    initial begin
        tv[0]  = mk(0, 0, 1, B1, 0, 0, 0, 0,  1, 64'h8000_0000, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 1, B1, 0, 0, 0, 0,  1, 64'h8000_0008, 1, 2, 32'hAAAA_AAAA, 64'h8000_0000, 0, 0);
        tv[2]  = mk(0, 0, 1, B1, 0, 0, 0, 1,  0, 64'h8000_0010, 1, 4, 32'hAAAA_AAAA, 64'h8000_0000, 0, 1);
        tv[3]  = mk(0, 0, 1, B1, 0, 0, 1, 0,  0, 64'h8000_0010, 1, 4, 32'hAAAA_AAAA, 64'h8000_0000, 0, 0);
        tv[4]  = mk(0, 0, 1, B1, 0, 0, 0, 0,  0, 64'h8000_0010, 1, 3, 32'hBBBB_BBBB, 64'h8000_0004, 0, 0);
        tv[5]  = mk(1, 64'h1004, 1, B1, 0, 0, 1, 0,  0, 64'h8000_0010, 1, 3, 32'hBBBB_BBBB, 64'h8000_0004, 0, 0);
        tv[6]  = mk(0, 0, 1, B2, 0, 0, 0, 0,  1, 64'h1004, 0, 0, 0, 0, 0, 0);
        tv[7]  = mk(0, 0, 0, B2, 0, 0, 0, 0,  1, 64'h1008, 1, 1, 32'h2222_2222, 64'h1004, 0, 0);
        tv[8]  = mk(0, 0, 0, B2, 0, 0, 1, 1,  1, 64'h1008, 1, 1, 32'h2222_2222, 64'h1004, 0, 1);
        tv[9]  = mk(0, 0, 0, B2, 0, 0, 0, 1,  1, 64'h1008, 0, 0, 0, 0, 0, 0);
        tv[10] = mk(1, 64'h2000, 0, B1, 0, 0, 0, 0,  0, 64'h1008, 0, 0, 0, 0, 0, 0);
        tv[11] = mk(0, 0, 1, B1, 0, 1, 0, 0,  1, 64'h2000, 0, 0, 0, 0, 0, 0);
        tv[12] = mk(0, 0, 1, B1, 0, 0, 0, 0,  0, 64'h2000, 1, 1, 0, 64'h2000, 3'b010, 0);
        tv[13] = mk(0, 0, 1, B1, 0, 0, 0, 0,  0, 64'h2000, 1, 1, 0, 64'h2000, 3'b010, 0);
        tv[14] = mk(1, 64'h3002, 1, B1, 0, 0, 0, 0,  0, 64'h2000, 1, 1, 0, 64'h2000, 3'b010, 0);
        tv[15] = mk(0, 0, 1, B1, 0, 0, 0, 1,  0, 64'h3002, 0, 0, 0, 0, 0, 0);
        tv[16] = mk(0, 0, 1, B1, 0, 0, 0, 1,  0, 64'h3002, 1, 1, 0, 64'h3002, 3'b001, 1);
        tv[17] = mk(0, 0, 1, B1, 0, 0, 1, 0,  0, 64'h3002, 1, 1, 0, 64'h3002, 3'b001, 0);

        rst = 1'b1;
        drive(0, 0, 1, B1, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rd", bus.rd, 1'b0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_qcount", bus.q_count, 0);
        chk("rst_addr", bus.addr, PC_RST);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tv[i].fl, tv[i].npc, tv[i].cr, tv[i].beat, tv[i].acc, tv[i].page, tv[i].idr, tv[i].irq);
            tbl_idx = i;
            step();
        end
        tbl_idx = -1;

        drive(1, 64'h4000, 0, 0, 0, 0, 0, 0);
        step();
        stream = 1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, {$urandom, $urandom}, 0, 0, 1, 0);
            step();
        end
        stream = 0;
        chk("stream_pops", npops >= 15, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            logic [63:0] npc;
            npc = {32'h0, $urandom} & ~64'h7;
            if ($urandom_range(3) == 0) npc[1:0] = 2'($urandom);
            if ($urandom_range(1) == 0) npc[2] = 1'b1;
            drive($urandom_range(15) == 0, npc, $urandom_range(2) != 0, {$urandom, $urandom},
                  $urandom_range(23) == 0, $urandom_range(23) == 0, 1'($urandom), 1'($urandom));
            step();
        end

        drive(1, 64'h5000, 0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, {$urandom, $urandom}, 0, 0, 0, 1);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.valid, 1'b0);
        chk("async_rst_rd", bus.rd, 1'b0);
        chk("async_rst_qcount", bus.q_count, 0);
        chk("async_rst_ins", bus.ins_out, 0);
        chk("async_rst_ipc", bus.ins_pc, 0);
        chk("async_rst_iacc", bus.int_acc, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("post_rst_addr", bus.addr, PC_RST);
        step();
        drive(0, 0, 1, B2, 0, 0, 0, 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ins_fetch_queue.md
Name: ins_fetch_queue

Overview:
- Parametrised next-generation IF stage for PRV464.
- Decouples instruction fetch from ID with a DEPTH-entry prefetch queue.
- Extracts up to two 32-bit instructions per 64-bit cache beat.
- Carries per-instruction PC and fault flags; halts fetch after a fault until a pipeline flush.
- Sits between the L1 I-cache/BIU port and the ID stage; replaces the hold-register scheme with a valid/ready handshake.

Parameters:
- PC_RST, 64'h0000_0000_0000_0000, PC loaded on reset.
- DEPTH, 4, queue entries; power of two, >=2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- priv  in  4  current privilege
- int_req  in  1  interrupt request from interrupt controller
- pip_flush  in  1  flush; redirect to new_pc
- new_pc  in  64  redirect target
- addr  out  64  fetch address (= pc)
- rd  out  1  fetch request
- if_priv  out  4  = priv
- ins_in  in  64  cache beat, valid when rd&cache_ready
- ins_acc_fault_biu  in  1  access fault for current beat
- ins_page_fault_biu  in  1  page fault for current beat
- cache_ready  in  1  beat for addr returned this cycle
- id_ready  in  1  ID consumes head this cycle
- ins_out  out  32  head instruction
- ins_pc  out  64  head PC
- ins_acc_fault  out  1  head access-fault flag
- ins_addr_mis  out  1  head misaligned flag
- ins_page_fault  out  1  head page-fault flag
- int_acc  out  1  interrupt attached to head
- valid  out  1  queue non-empty
- q_count  out  CW  occupancy

Behaviour:
- Reset (async, rst=1):
  - pc=PC_RST; queue empty (rd/wr pointers 0, q_count=0); state=RUN.
  - valid=0, rd=0; ins_out, ins_pc and all flags 0.
  - Head outputs are driven 0 whenever the queue is empty.
- Entry format: {ins[31:0], pc[63:0], acc, page, mis}.
- Free slots: free = DEPTH - q_count, taken before this cycle's pop.
- States:
  - RUN: rd = !pip_flush & free>=2 & pc[1:0]==0.
  - HALT: rd=0; entered after any fault entry is pushed; left only by pip_flush.
- Beat accept: rd&cache_ready.
  - No fault, pc[2]==0: push {ins_in[31:0],pc} then {ins_in[63:32],pc+4}; pc+=8.
  - No fault, pc[2]==1: push {ins_in[63:32],pc}; pc+=4.
  - Fault (acc or page): push one entry {32'h0, pc, acc, page, 0}; pc unchanged; go HALT.
  - If acc and page both assert, both flags are set.
- Misalignment:
  - In RUN with pc[1:0]!=0 and free>=1, push {0, pc, 0, 0, 1} without a cache access; go HALT.
- Pop: valid&id_ready removes the head.
  - Push and pop in the same cycle are both performed; q_count += pushes - pops.
  - Never overflows (rd gated on free>=2).
- Head outputs are combinational from the head entry registers; latency from accepted beat to valid is 1 cycle.
- int_acc = valid & int_req. The interrupt marks the head instruction; ID owns the drain decision.
- pip_flush has priority over everything in its cycle:
  - Queue cleared; any beat or pop that cycle is discarded.
  - pc <= new_pc; state <= RUN.
  - valid=0 the next cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Two-entry pushes may straddle the wrap boundary.
- addr = pc at all times; if_priv = priv.

Test Plan:
- Reset with PC_RST=64'h8000_0000, cache_ready=1, beat 64'hBBBB_BBBB_AAAA_AAAA, id_ready=0.
  -> addr 8000_0000, rd=1 first cycle.
  -> head AAAA_AAAA@8000_0000, then BBBB_BBBB@8000_0004; pc 8000_0008.
  -> rd drops when q_count=3 (DEPTH=4).
- pip_flush with new_pc=64'h1004 while 3 entries are queued.
  -> next cycle valid=0, q_count=0.
  -> first push is only ins_in[63:32] @1004; pc=1008.
- Beat with ins_page_fault_biu=1 at pc 2000.
  -> one entry pc=2000, ins_page_fault=1, ins_out=0.
  -> rd stays 0 until pip_flush.
- Flush to new_pc=64'h3002.
  -> no rd; entry pc=3002, ins_addr_mis=1; HALT.
- Continuous id_ready=1 and cache_ready=1 for 20 cycles (DEPTH=4).
  -> pointers wrap; PCs strictly +4 sequential, no loss/duplication; q_count never exceeds 4.
- int_req=1 with valid=1 -> int_acc=1 same cycle; with queue empty -> int_acc=0.
- Assert rst mid-stream -> all outputs 0 immediately (asynchronous); after release pc=PC_RST.
